// File: rtl/ones_frame_accumulator_pkg.sv
// Shared types and constants for the ones frame accumulator.
// Popcounts arrive from an 8-bit one_counter, so a legal beat carries 0..8.
package ones_pkg;

    localparam int POP_W = 4;
    localparam logic [POP_W-1:0] POP_MAX = 4'd8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Out-of-range popcounts are treated as a full byte of ones.
    function automatic logic [POP_W-1:0] clamp_pop(input logic [POP_W-1:0] cnt);
        return (cnt > POP_MAX) ? POP_MAX : cnt;
    endfunction

endpackage

// File: rtl/ones_frame_accumulator_if.sv
// Beat input and frame-result output of the ones frame accumulator.
// The accumulator uses the slave view; the producer/consumer side uses master.
interface ones_frame_accumulator_if #(
    parameter int SUM_W = 12,
    parameter int LEN_W = 9
);
    import ones_pkg::*;

    logic [POP_W-1:0] count_in;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [SUM_W-1:0] out_sum;
    logic [LEN_W-1:0] out_len;
    logic             out_sat;
    logic             out_err;

    modport slave (
        input  count_in, in_valid, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_len, out_sat, out_err
    );

    modport master (
        output count_in, in_valid, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_len, out_sat, out_err
    );

endinterface

// File: rtl/ones_frame_accumulator_sat_add.sv
// Unsigned saturating adder: a_i + b_i clipped to all-ones, with an overflow flag.
module sat_add #(
    parameter int W   = 12,
    parameter int B_W = 4
) (
    input  logic [W-1:0]   a_i,
    input  logic [B_W-1:0] b_i,
    output logic [W-1:0]   sum_o,
    output logic           ovf_o
);

    logic [W:0] full;

    // One guard bit catches the carry out; B_W must not exceed W.
    assign full  = {1'b0, a_i} + {{(W + 1 - B_W){1'b0}}, b_i};
    assign ovf_o = full[W];
    assign sum_o = full[W] ? {W{1'b1}} : full[W-1:0];

endmodule

// File: rtl/ones_frame_accumulator.sv
// Accumulates popcounts and byte counts over in_last-delimited frames and
// presents one result per frame on a valid/ready port with upstream backpressure.
module ones_frame_accumulator #(
    parameter int SUM_W = 12,
    parameter int LEN_W = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    ones_frame_accumulator_if.slave  strm
);
    import ones_pkg::*;

    state_e           state_q, state_d;
    logic [SUM_W-1:0] acc_sum_q, acc_sum_d;
    logic [LEN_W-1:0] acc_len_q, acc_len_d;
    logic             sat_q, sat_d;
    logic             err_q, err_d;

    logic             out_valid_q, out_valid_d;
    logic [SUM_W-1:0] out_sum_q, out_sum_d;
    logic [LEN_W-1:0] out_len_q, out_len_d;
    logic             out_sat_q, out_sat_d;
    logic             out_err_q, out_err_d;

    logic             in_ready;
    logic             accept;
    logic             complete;
    logic [SUM_W-1:0] sum_nxt;
    logic [LEN_W-1:0] len_nxt;
    logic             sum_ovf, len_ovf;
    logic             sat_nxt, err_nxt;

    assign in_ready = !out_valid_q || strm.out_ready;
    assign accept   = strm.in_valid && in_ready && !clear;
    assign complete = accept && strm.in_last;

    sat_add #(.W(SUM_W), .B_W(POP_W)) u_sum_add (
        .a_i   (acc_sum_q),
        .b_i   (clamp_pop(strm.count_in)),
        .sum_o (sum_nxt),
        .ovf_o (sum_ovf)
    );

    sat_add #(.W(LEN_W), .B_W(1)) u_len_add (
        .a_i   (acc_len_q),
        .b_i   (1'b1),
        .sum_o (len_nxt),
        .ovf_o (len_ovf)
    );

    assign sat_nxt = sat_q || sum_ovf || len_ovf;
    assign err_nxt = err_q || (strm.count_in > POP_MAX);

    // A completing beat hands its totals to the output register and restarts from zero.
    always_comb begin
        state_d   = state_q;
        acc_sum_d = acc_sum_q;
        acc_len_d = acc_len_q;
        sat_d     = sat_q;
        err_d     = err_q;
        if (clear || complete) begin
            state_d   = IDLE;
            acc_sum_d = '0;
            acc_len_d = '0;
            sat_d     = 1'b0;
            err_d     = 1'b0;
        end else if (accept) begin
            state_d   = ACCUM;
            acc_sum_d = sum_nxt;
            acc_len_d = len_nxt;
            sat_d     = sat_nxt;
            err_d     = err_nxt;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_len_d   = out_len_q;
        out_sat_d   = out_sat_q;
        out_err_d   = out_err_q;
        if (complete) begin
            out_valid_d = 1'b1;
            out_sum_d   = sum_nxt;
            out_len_d   = len_nxt;
            out_sat_d   = sat_nxt;
            out_err_d   = err_nxt;
        end else if (strm.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_sum_q   <= '0;
            acc_len_q   <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_len_q   <= '0;
            out_sat_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_sum_q   <= acc_sum_d;
            acc_len_q   <= acc_len_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_len_q   <= out_len_d;
            out_sat_q   <= out_sat_d;
            out_err_q   <= out_err_d;
        end
    end

    assign strm.in_ready  = in_ready;
    assign strm.out_valid = out_valid_q;
    assign strm.out_sum   = out_sum_q;
    assign strm.out_len   = out_len_q;
    assign strm.out_sat   = out_sat_q;
    assign strm.out_err   = out_err_q;

endmodule

// File: doc/ones_frame_accumulator.md
Name: ones_frame_accumulator

Overview:
- Sequential stage directly downstream of the combinational one_counter (8-bit In -> 4-bit popcount Out).
- Consumes one popcount per accepted byte beat and accumulates the total number of ones and the byte count over a framed stream delimited by in_last.
- Presents one result per frame on a valid/ready output port.
- Provides backpressure upstream while a result is stalled.

Parameters:
- SUM_W, 12, width of the ones total; saturates at 2^SUM_W-1.
- LEN_W, 9, width of the byte-count field; saturates at 2^LEN_W-1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort of the frame in progress.
- count_in  in  4  popcount of the current byte, from one_counter; legal range 0..8.
- in_valid  in  1  count_in is valid this cycle.
- in_last  in  1  current beat is the final byte of the frame.
- in_ready  out  1  stage can accept a beat this cycle.
- out_valid  out  1  frame result held on the out_* ports.
- out_ready  in  1  consumer takes the result this cycle.
- out_sum  out  SUM_W  total ones in the frame.
- out_len  out  LEN_W  bytes in the frame.
- out_sat  out  1  out_sum or out_len saturated during the frame.
- out_err  out  1  at least one beat had count_in > 8.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State returns to IDLE.
  - acc_sum, acc_len and the sticky flags go to 0.
  - out_valid, out_sum, out_len, out_sat and out_err go to 0.
  - Any partial frame is discarded.
- in_ready is combinational: !out_valid || out_ready. It is 1 out of reset.
- A beat is accepted when in_valid && in_ready. There are no side effects when no beat is accepted.
- Per accepted beat:
  - eff = (count_in > 8) ? 8 : count_in. err_sticky is set if count_in > 8.
  - acc_sum += eff and acc_len += 1. Each saturates at all-ones. sat_sticky is set when a saturating add would overflow.
  - Beats with count_in = 0 still count toward out_len.
- FSM states:
  - IDLE: no frame open. An accepted beat without in_last moves to ACCUM. An accepted beat with in_last completes a single-byte frame and stays in IDLE.
  - ACCUM: frame open. Accepted beats without in_last stay in ACCUM. An accepted beat with in_last completes the frame and moves to IDLE.
- On frame completion:
  - The next-state sum, len and flags (including the last beat) load into the output registers. out_valid is 1 in the following cycle (latency 1 clock from the last beat).
  - Accumulators and sticky flags clear to 0 in the same edge, so the next frame starts from zero with no bubble.
- Output handshake:
  - out_* are stable while out_valid && !out_ready.
  - out_valid drops on the edge where out_ready is 1, unless a new frame completes on that same edge. In that case out_valid stays 1 and the new result loads (back-to-back single-byte frames sustain 1 result per clock).
  - While out_valid && !out_ready, in_ready is 0 and no beats are accepted, including non-last beats.
- clear (synchronous):
  - Drops the frame in progress: accumulators and flags go to 0 and state goes to IDLE.
  - A beat presented in the same cycle is ignored; clear has priority.
  - The pending output register and out_valid are unaffected.
- in_valid low in ACCUM is a gap: state is held indefinitely.
- in_last is ignored when in_valid is low or the beat is not accepted.

Decomposition:
- Shared package ones_pkg holds:
  - the state enum {IDLE, ACCUM};
  - localparam POP_MAX = 8;
  - POP_W = 4.
- One natural sub-module, sat_add (parameterised width), is instantiated twice, for sum and len. It returns the saturated result plus an overflow flag.
- The one_counter instance stays outside this block; the integration wrapper connects its Out to count_in.

Test Plan:
- Reset, then a 3-beat frame with counts 8,8,8 (last on beat 3), out_ready=1 -> one cycle after beat 3: out_valid=1, out_sum=24, out_len=3, out_sat=0, out_err=0.
- Single-beat frames with counts 5 then 0 on consecutive cycles, out_ready=1 -> results (5,1) then (0,1) on consecutive cycles; in_ready stays 1 throughout.
- Frame completes with out_ready=0 held 4 cycles while in_valid=1 -> in_ready=0 and out_* stable for those 4 cycles; no beat counted; after out_ready=1 the stalled beat is accepted and starts a new frame.
- SUM_W=5, 5-beat frame of count 8 -> out_sum=31, out_sat=1. A separate beat with count_in=12 -> counted as 8, out_err=1.
- 2 beats of a frame (counts 3,4), then clear=1 with in_valid=1, then a 1-beat last frame of count 2 -> result out_sum=2, out_len=1.
- rst_n pulsed low mid-frame (after counts 7,7), asynchronously off-edge -> all outputs 0 immediately. The next frame with count 1 (last) -> out_sum=1, out_len=1.
